// File: rtl/br_multipuerto.sv
// Multi-port register file: NRD combinational read ports, one write port, pending-write
// scoreboard and sequential clear engine. Define BR_PARITY_EN for per-register even parity.
module br_multipuerto #(
  parameter int unsigned W        = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*W-1:0]  rd,
  output logic [NRD-1:0]    rd_pend,
  output logic [NRD-1:0]    rd_perr,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [W-1:0]      wd,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [AW-1:0] FIRST_IDX = AW'((ZERO_REG != 0) ? 1 : 0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  logic [W-1:0]     regs_q [DEPTH];
  logic [W-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             clr_busy_q, clr_busy_d;
  logic             wr_ok_c, set_ok_c;
`ifdef BR_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
`endif

  // Writes and scoreboard sets are dropped while clearing, to register 0 and out of range
  assign wr_ok_c  = we && !clr_busy_q && (32'(wa) < DEPTH)
                    && !((ZERO_REG != 0) && (wa == '0));
  assign set_ok_c = sb_set && !clr_busy_q && (32'(sb_addr) < DEPTH)
                    && !((ZERO_REG != 0) && (sb_addr == '0));

  // Next-state: write port, scoreboard and clear sweep
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_busy_d = clr_busy_q;
    regs_d     = regs_q;
    pend_d     = pend_q;
`ifdef BR_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_ok_c) begin
          regs_d[wa] = wd;
          pend_d[wa] = 1'b0;
`ifdef BR_PARITY_EN
          par_d[wa]  = ^wd;
`endif
        end
        // A set on the same edge as a write wins
        if (set_ok_c) pend_d[sb_addr] = 1'b1;
        if (clr_req) begin
          state_d    = CLEAR;
          idx_d      = FIRST_IDX;
          clr_busy_d = 1'b1;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        pend_d[idx_q] = 1'b0;
`ifdef BR_PARITY_EN
        par_d[idx_q]  = 1'b0;
`endif
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          state_d    = IDLE;
          idx_d      = '0;
          clr_busy_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        clr_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      regs_q     <= '{default: '0};
      pend_q     <= '0;
`ifdef BR_PARITY_EN
      par_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_busy_q <= clr_busy_d;
      regs_q     <= regs_d;
      pend_q     <= pend_d;
`ifdef BR_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign clr_busy = clr_busy_q;

  // Combinational read ports; forced to 0 while reset is held
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] addr_c;
    logic          valid_c;
    logic          byp_c;

    assign addr_c  = ra[g*AW +: AW];
    assign valid_c = rst_n && (32'(addr_c) < DEPTH)
                     && !((ZERO_REG != 0) && (addr_c == '0));
    assign byp_c   = (BYPASS != 0) && valid_c && we && (wa == addr_c) && !clr_busy_q;

    assign rd[g*W +: W] = !valid_c ? '0 : (byp_c ? wd : regs_q[addr_c]);
    assign rd_pend[g]   = valid_c && pend_q[addr_c];
`ifdef BR_PARITY_EN
    assign rd_perr[g]   = valid_c && !byp_c && (par_q[addr_c] != ^regs_q[addr_c]);
`else
    assign rd_perr[g]   = 1'b0;
`endif
  end

endmodule
